pong_frame_renderer: RTL and testbench
======================================

Name: pong_frame_renderer

Overview:
- Parametrised, pipelined pixel renderer for the Pong display. It sits between the VGA timing counters and the DAC/colour outputs.
- Object positions are latched once per frame into shadow registers, so the picture never tears.
- Draws two paddles, the ball, and an optional dashed centre net.
- Supports a post-goal ball-hide window. Edge-clamped arithmetic means objects near the screen edges never wrap.

Parameters:
- H_RES, 640, active pixels per line
- V_RES, 480, active lines per frame
- PADDLE_W, 10, paddle width in pixels
- PADDLE_H, 60, paddle height in pixels (even)
- BALL_SIZE, 8, ball side length in pixels (even)
- PADDLE_MARGIN, 30, gap from the screen edge to the outer paddle edge
- COLOR_W, 8, bits per colour channel
- NET_W, 2, net width in pixels, centred on H_RES/2
- DASH_LOG2, 4, net dash period half-length = 2**DASH_LOG2 lines
- HIDE_FRAMES, 60, frames the ball stays hidden after a goal pulse

Ports:
- vgaclk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- x  in  10  current pixel column
- y  in  10  current pixel row
- pix_valid  in  1  x/y lie in the active area
- frame_start  in  1  one-cycle pulse at the start of vertical blanking
- paddle1_y  in  10  left paddle centre Y
- paddle2_y  in  10  right paddle centre Y
- ball_x  in  10  ball centre X
- ball_y  in  10  ball centre Y
- goal  in  1  one-cycle pulse: a point was scored
- net_en  in  1  enable centre net
- red  out  COLOR_W  red channel
- green  out  COLOR_W  green channel
- blue  out  COLOR_W  blue channel
- pix_valid_out  out  1  pix_valid delayed to align with the colour outputs
- ball_hidden  out  1  hide window active

Behaviour:
- Reset (async, active-high):
  - shadow paddles = V_RES/2; shadow ball = (H_RES/2, V_RES/2); shadow net_en = 0
  - hide counter = 0
  - all pipeline registers 0, so red/green/blue = 0, pix_valid_out = 0, ball_hidden = 0
- Shadow latch: on a vgaclk edge with frame_start=1, copy paddle1_y, paddle2_y, ball_x, ball_y and net_en into the shadow registers. Outside that edge, changes on these inputs have no effect. All drawing uses the shadow values only.
- Clamping at latch:
  - paddle centre clamped to [PADDLE_H/2, V_RES-PADDLE_H/2]
  - ball_x clamped to [BALL_SIZE/2, H_RES-BALL_SIZE/2]
  - ball_y clamped to [BALL_SIZE/2, V_RES-BALL_SIZE/2]
  - All compares are performed at 11 bits unsigned, so no subtraction underflows.
- Hit regions (half-open intervals):
  - paddle1: x in [PADDLE_MARGIN, PADDLE_MARGIN+PADDLE_W), y in [c-PADDLE_H/2, c+PADDLE_H/2)
  - paddle2: x in [H_RES-PADDLE_MARGIN-PADDLE_W, H_RES-PADDLE_MARGIN), same y rule
  - ball: x in [bx-BALL_SIZE/2, bx+BALL_SIZE/2), y likewise, and ball_hidden=0
  - net: net_en_shadow=1, x in [H_RES/2-NET_W/2, H_RES/2+NET_W/2), and y[DASH_LOG2]==0
- Priority: paddles, then ball, then net, then background.
  - Paddle and ball pixels are white (all ones).
  - Net pixels are grey (channel = 2**(COLOR_W-1)).
  - Background pixels are 0.
- Pipeline, fixed 2-cycle latency:
  - Stage 1 registers the four hit flags and pix_valid.
  - Stage 2 registers the colour and pix_valid_out.
  - Colour is forced to 0 whenever the stage-2 valid is 0 (blanking).
  - No stalls; one pixel per cycle.
- Hide counter:
  - goal=1 loads HIDE_FRAMES.
  - Otherwise, frame_start=1 with a nonzero count decrements it by 1.
  - ball_hidden is registered and equals (count != 0).
  - goal and frame_start in the same cycle: load wins; that cycle produces no decrement.
  - goal during an active window reloads to HIDE_FRAMES.
  - Count saturates at 0.
- frame_start asserted on consecutive cycles: each edge relatches and decrements. Not an error.
- Reset mid-frame: outputs go to 0 immediately. After release, drawing uses the default centred positions until the next frame_start.

Test Plan:
- After reset, with x=30, y=240, pix_valid=1 and no frame_start: red/green/blue=FF and pix_valid_out=1 exactly 2 cycles later. With x=29: output 00.
- paddle1_y=10, then frame_start: clamped to 30. Pixel (35,0) is FF; pixel (35,60) is 00. pixel (35,479) is 00 (no wrap).
- ball_x=100 and ball_y=100 changed mid-frame without frame_start: (100,100) stays 00. After frame_start, (96,96) is FF and (104,100) is 00.
- goal pulse followed by 60 frame_start pulses: ball_hidden=1 and the ball pixel is 00 for the first 59 frames. ball_hidden=0 after the 60th. goal coincident with frame_start: count=60, not 59.
- net_en=1 latched, x=320: y=5 gives 80, y=20 gives 00. Ball overlapping the net at (320,5) gives FF (ball priority).
- pix_valid=0 at a paddle pixel gives 00 output with pix_valid_out=0. Asserting reset mid-stream clears all outputs in the same cycle.

Source files
------------

// File: rtl/pong_frame_renderer.sv
// rtl/pong_frame_renderer.sv - Pong pixel renderer with per-frame shadow latch
// Two-stage pipeline: hit detection, then colour select with blanking.
module pong_frame_renderer #(
  parameter int H_RES         = 640,
  parameter int V_RES         = 480,
  parameter int PADDLE_W      = 10,
  parameter int PADDLE_H      = 60,
  parameter int BALL_SIZE     = 8,
  parameter int PADDLE_MARGIN = 30,
  parameter int COLOR_W       = 8,
  parameter int NET_W         = 2,
  parameter int DASH_LOG2     = 4,
  parameter int HIDE_FRAMES   = 60
) (
  input  logic               vgaclk,
  input  logic               reset,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic               pix_valid,
  input  logic               frame_start,
  input  logic [9:0]         paddle1_y,
  input  logic [9:0]         paddle2_y,
  input  logic [9:0]         ball_x,
  input  logic [9:0]         ball_y,
  input  logic               goal,
  input  logic               net_en,
  output logic [COLOR_W-1:0] red,
  output logic [COLOR_W-1:0] green,
  output logic [COLOR_W-1:0] blue,
  output logic               pix_valid_out,
  output logic               ball_hidden
);

  localparam int CNT_W = $clog2(HIDE_FRAMES + 2);

  localparam logic [10:0] P_HALF  = 11'(PADDLE_H / 2);
  localparam logic [10:0] B_HALF  = 11'(BALL_SIZE / 2);
  localparam logic [10:0] P_MIN   = P_HALF;
  localparam logic [10:0] P_MAX   = 11'(V_RES - PADDLE_H / 2);
  localparam logic [10:0] BX_MAX  = 11'(H_RES - BALL_SIZE / 2);
  localparam logic [10:0] BY_MAX  = 11'(V_RES - BALL_SIZE / 2);
  localparam logic [10:0] P1_X0   = 11'(PADDLE_MARGIN);
  localparam logic [10:0] P1_X1   = 11'(PADDLE_MARGIN + PADDLE_W);
  localparam logic [10:0] P2_X0   = 11'(H_RES - PADDLE_MARGIN - PADDLE_W);
  localparam logic [10:0] P2_X1   = 11'(H_RES - PADDLE_MARGIN);
  localparam logic [10:0] NET_X0  = 11'(H_RES / 2 - NET_W / 2);
  localparam logic [10:0] NET_X1  = 11'(H_RES / 2 + NET_W / 2);
  localparam logic [9:0]  P_RST   = 10'(V_RES / 2);
  localparam logic [9:0]  BX_RST  = 10'(H_RES / 2);
  localparam logic [9:0]  BY_RST  = 10'(V_RES / 2);
  localparam logic [COLOR_W-1:0] WHITE = {COLOR_W{1'b1}};
  localparam logic [COLOR_W-1:0] GREY  = COLOR_W'(2 ** (COLOR_W - 1));

  function automatic logic [9:0] clamp(input logic [9:0] v, input logic [10:0] lo,
                                       input logic [10:0] hi);
    logic [10:0] w;
    w = {1'b0, v};
    if (w < lo)      return lo[9:0];
    else if (w > hi) return hi[9:0];
    else             return v;
  endfunction

  logic [9:0]       p1_q, p1_d, p2_q, p2_d, bx_q, bx_d, by_q, by_d;
  logic             net_en_q, net_en_d;
  logic [CNT_W-1:0] hide_cnt_q, hide_cnt_d;
  logic             hidden_q, hidden_d;
  logic             hit_p1_q, hit_p1_d, hit_p2_q, hit_p2_d;
  logic             hit_ball_q, hit_ball_d, hit_net_q, hit_net_d;
  logic             v1_q, v1_d, v2_q, v2_d;
  logic [COLOR_W-1:0] color_q, color_d;

  logic [10:0] x_w, y_w;
  assign x_w = {1'b0, x};
  assign y_w = {1'b0, y};

  // Shadow registers and the post-goal hide counter; goal load beats decrement.
  always_comb begin
    p1_d       = p1_q;
    p2_d       = p2_q;
    bx_d       = bx_q;
    by_d       = by_q;
    net_en_d   = net_en_q;
    hide_cnt_d = hide_cnt_q;
    if (frame_start) begin
      p1_d     = clamp(paddle1_y, P_MIN, P_MAX);
      p2_d     = clamp(paddle2_y, P_MIN, P_MAX);
      bx_d     = clamp(ball_x, B_HALF, BX_MAX);
      by_d     = clamp(ball_y, B_HALF, BY_MAX);
      net_en_d = net_en;
    end
    if (goal)
      hide_cnt_d = CNT_W'(HIDE_FRAMES);
    else if (frame_start && hide_cnt_q != '0)
      hide_cnt_d = hide_cnt_q - CNT_W'(1);
    hidden_d = (hide_cnt_d != '0);
  end

  // Stage 1: hit flags from shadow values (bounds cannot underflow after clamping).
  always_comb begin
    hit_p1_d   = (x_w >= P1_X0) && (x_w < P1_X1) &&
                 (y_w >= {1'b0, p1_q} - P_HALF) && (y_w < {1'b0, p1_q} + P_HALF);
    hit_p2_d   = (x_w >= P2_X0) && (x_w < P2_X1) &&
                 (y_w >= {1'b0, p2_q} - P_HALF) && (y_w < {1'b0, p2_q} + P_HALF);
    hit_ball_d = !hidden_q &&
                 (x_w >= {1'b0, bx_q} - B_HALF) && (x_w < {1'b0, bx_q} + B_HALF) &&
                 (y_w >= {1'b0, by_q} - B_HALF) && (y_w < {1'b0, by_q} + B_HALF);
    hit_net_d  = net_en_q && (x_w >= NET_X0) && (x_w < NET_X1) && !y[DASH_LOG2];
    v1_d       = pix_valid;
  end

  // Stage 2: priority colour select, blanked when invalid.
  always_comb begin
    v2_d    = v1_q;
    color_d = '0;
    if (v1_q) begin
      if (hit_p1_q || hit_p2_q || hit_ball_q) color_d = WHITE;
      else if (hit_net_q)                     color_d = GREY;
    end
  end

  always_ff @(posedge vgaclk or posedge reset) begin
    if (reset) begin
      p1_q       <= P_RST;
      p2_q       <= P_RST;
      bx_q       <= BX_RST;
      by_q       <= BY_RST;
      net_en_q   <= 1'b0;
      hide_cnt_q <= '0;
      hidden_q   <= 1'b0;
      hit_p1_q   <= 1'b0;
      hit_p2_q   <= 1'b0;
      hit_ball_q <= 1'b0;
      hit_net_q  <= 1'b0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      color_q    <= '0;
    end else begin
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      bx_q       <= bx_d;
      by_q       <= by_d;
      net_en_q   <= net_en_d;
      hide_cnt_q <= hide_cnt_d;
      hidden_q   <= hidden_d;
      hit_p1_q   <= hit_p1_d;
      hit_p2_q   <= hit_p2_d;
      hit_ball_q <= hit_ball_d;
      hit_net_q  <= hit_net_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      color_q    <= color_d;
    end
  end

  assign red           = color_q;
  assign green         = color_q;
  assign blue          = color_q;
  assign pix_valid_out = v2_q;
  assign ball_hidden   = hidden_q;

endmodule

// File: tb/tb_pong_frame_renderer.sv
// tb/tb_pong_frame_renderer.sv - directed and randomized checks of pong_frame_renderer
// Expected pixels come from a geometric model of the screen objects.
module tb_pong_frame_renderer;

  logic       vgaclk = 1'b0;
  logic       reset;
  logic [9:0] x, y, paddle1_y, paddle2_y, ball_x, ball_y;
  logic       pix_valid, frame_start, goal, net_en;
  logic [7:0] red, green, blue;
  logic       pix_valid_out, ball_hidden;

  int checks = 0;
  int errors = 0;

  int s_p1, s_p2, s_bx, s_by, m_hide;
  bit s_net;

  always #5 vgaclk = ~vgaclk;

  pong_frame_renderer dut (
    .vgaclk(vgaclk), .reset(reset), .x(x), .y(y), .pix_valid(pix_valid),
    .frame_start(frame_start), .paddle1_y(paddle1_y), .paddle2_y(paddle2_y),
    .ball_x(ball_x), .ball_y(ball_y), .goal(goal), .net_en(net_en),
    .red(red), .green(green), .blue(blue), .pix_valid_out(pix_valid_out),
    .ball_hidden(ball_hidden)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int lim(input int v, input int lo, input int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic logic [7:0] ref_pix(input int px, input int py, input bit pv);
    bit pad, ball, net;
    if (!pv) return 8'h00;
    pad  = (py >= s_p1 - 30 && py < s_p1 + 30 && px >= 30 && px < 40) ||
           (py >= s_p2 - 30 && py < s_p2 + 30 && px >= 600 && px < 610);
    ball = (m_hide == 0) && px >= s_bx - 4 && px < s_bx + 4 &&
           py >= s_by - 4 && py < s_by + 4;
    net  = s_net && (px == 319 || px == 320) && ((py / 16) % 2 == 0);
    if (pad || ball) return 8'hFF;
    if (net) return 8'h80;
    return 8'h00;
  endfunction

  task automatic pix(input int px, input int py, input bit pv, input logic [7:0] ec,
                     input string tag);
    @(negedge vgaclk);
    x = 10'(px); y = 10'(py); pix_valid = pv;
    @(posedge vgaclk);
    @(negedge vgaclk);
    x = '0; y = '0; pix_valid = 1'b0;
    @(posedge vgaclk);
    #1;
    chk({tag, "_rgb"}, {8'h0, red, green, blue}, {8'h0, ec, ec, ec});
    chk({tag, "_vld"}, 32'(pix_valid_out), 32'(pv));
  endtask

  task automatic pulse(input bit fs, input bit g);
    @(negedge vgaclk);
    frame_start = fs; goal = g;
    @(posedge vgaclk);
    if (g) m_hide = 60;
    else if (fs && m_hide > 0) m_hide--;
    if (fs) begin
      s_p1  = lim(int'(paddle1_y), 30, 450);
      s_p2  = lim(int'(paddle2_y), 30, 450);
      s_bx  = lim(int'(ball_x), 4, 636);
      s_by  = lim(int'(ball_y), 4, 476);
      s_net = net_en;
    end
    #1;
    frame_start = 1'b0; goal = 1'b0;
  endtask

  initial begin
    int px, py, sel;
    bit pv;
    reset = 1'b1; x = '0; y = '0; pix_valid = 1'b0; frame_start = 1'b0; goal = 1'b0;
    paddle1_y = 10'd240; paddle2_y = 10'd240; ball_x = 10'd320; ball_y = 10'd240;
    net_en = 1'b0;
    s_p1 = 240; s_p2 = 240; s_bx = 320; s_by = 240; s_net = 0; m_hide = 0;
    repeat (3) @(posedge vgaclk);
    #1;
    chk("rst_rgb", {8'h0, red, green, blue}, 32'h0);
    chk("rst_vld", 32'(pix_valid_out), 32'h0);
    chk("rst_hid", 32'(ball_hidden), 32'h0);
    @(negedge vgaclk) reset = 1'b0;

    pix(30, 240, 1, 8'hFF, "p1_edge_in");
    pix(29, 240, 1, 8'h00, "p1_edge_out");

    paddle1_y = 10'd10;
    pulse(1, 0);
    pix(35, 0, 1, 8'hFF, "p1_clamp_top");
    pix(35, 60, 1, 8'h00, "p1_clamp_bot");
    pix(35, 479, 1, 8'h00, "p1_nowrap");

    ball_x = 10'd100; ball_y = 10'd100;
    pix(100, 100, 1, 8'h00, "ball_noshadow");
    pulse(1, 0);
    pix(96, 96, 1, 8'hFF, "ball_corner");
    pix(104, 100, 1, 8'h00, "ball_right");

    pulse(0, 1);
    chk("hide_load", 32'(ball_hidden), 32'h1);
    for (int k = 1; k <= 60; k++) begin
      pulse(1, 0);
      chk($sformatf("hide_f%0d", k), 32'(ball_hidden), 32'(m_hide != 0));
      pix(100, 100, 1, ref_pix(100, 100, 1), $sformatf("hide_pix%0d", k));
    end

    pulse(1, 1);
    repeat (59) pulse(1, 0);
    chk("coinc_59", 32'(ball_hidden), 32'h1);
    pulse(1, 0);
    chk("coinc_60", 32'(ball_hidden), 32'h0);

    pulse(0, 1);
    repeat (10) pulse(1, 0);
    pulse(0, 1);
    repeat (59) pulse(1, 0);
    chk("reload_59", 32'(ball_hidden), 32'(m_hide != 0));
    pulse(1, 0);
    chk("reload_60", 32'(ball_hidden), 32'h0);

    net_en = 1'b1;
    pulse(1, 0);
    pix(320, 5, 1, 8'h80, "net_dash");
    pix(320, 20, 1, 8'h00, "net_gap");
    ball_x = 10'd320; ball_y = 10'd5;
    pulse(1, 0);
    pix(320, 5, 1, 8'hFF, "ball_over_net");

    pix(35, 10, 0, 8'h00, "blank");

    for (int f = 0; f < 8; f++) begin
      paddle1_y = 10'($urandom_range(0, 1023));
      paddle2_y = 10'($urandom_range(0, 1023));
      ball_x    = 10'($urandom_range(0, 1023));
      ball_y    = 10'($urandom_range(0, 1023));
      net_en    = 1'($urandom_range(0, 1));
      pulse(1, 0);
      for (int i = 0; i < 20; i++) begin
        sel = $urandom_range(0, 4);
        case (sel)
          0: begin px = $urandom_range(25, 45);   py = s_p1 - 40 + $urandom_range(0, 80); end
          1: begin px = $urandom_range(595, 615); py = s_p2 - 40 + $urandom_range(0, 80); end
          2: begin px = s_bx - 8 + $urandom_range(0, 16); py = s_by - 8 + $urandom_range(0, 16); end
          3: begin px = $urandom_range(316, 324); py = $urandom_range(0, 479); end
          default: begin px = $urandom_range(0, 639); py = $urandom_range(0, 479); end
        endcase
        px = lim(px, 0, 1023);
        py = lim(py, 0, 1023);
        pv = ($urandom_range(0, 7) != 0);
        pix(px, py, pv, ref_pix(px, py, pv), $sformatf("rnd%0d_%0d", f, i));
      end
    end

    paddle1_y = 10'd10;
    pulse(1, 0);
    pulse(0, 1);
    @(negedge vgaclk);
    x = 10'd35; y = 10'd10; pix_valid = 1'b1;
    repeat (3) @(posedge vgaclk);
    #1;
    chk("pre_rst_rgb", {8'h0, red, green, blue}, 32'h00FFFFFF);
    chk("pre_rst_hid", 32'(ball_hidden), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_rgb", {8'h0, red, green, blue}, 32'h0);
    chk("mid_rst_vld", 32'(pix_valid_out), 32'h0);
    chk("mid_rst_hid", 32'(ball_hidden), 32'h0);
    @(negedge vgaclk);
    reset = 1'b0; pix_valid = 1'b0;
    s_p1 = 240; s_p2 = 240; s_bx = 320; s_by = 240; s_net = 0; m_hide = 0;
    pix(30, 240, 1, 8'hFF, "post_rst_default");
    pix(35, 10, 1, 8'h00, "post_rst_old_gone");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
